fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one synchronous FIFO write interface (wr_en/data_in/ready) between NREQ producers. Grants one requester at a time for a burst of up to MAX_BURST beats, then rotates the grant. Sits directly in front of the FIFO write port; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bursts of up to MAX_BURST beats.
// Optional macro FIFO_ARB_PRIO_EN: requester 0 wins every arbitration and does not advance the rotation.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_ready,
  output logic                      fifo_wr_en,
  output logic [WIDTH-1:0]          fifo_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   beat_cnt;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   exit_ptr;
  logic            g_valid;
  logic            xfer;
  logic            burst_done;

  // First set bit at or after ptr, wrapping explicitly at NREQ so non-power-of-2 counts work.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && v[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    return (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
`ifdef FIFO_ARB_PRIO_EN
    sel      = req_valid[0] ? '0 : rr_pick(req_valid, rr_ptr);
    exit_ptr = (grant_id == '0) ? rr_ptr : next_ptr(grant_id);
`else
    sel      = rr_pick(req_valid, rr_ptr);
    exit_ptr = next_ptr(grant_id);
`endif
  end

  assign g_valid    = req_valid[grant_id];
  assign xfer       = (state == BURST) && g_valid && fifo_ready;
  assign burst_done = !g_valid || (xfer && (beat_cnt == LAST_BEAT));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= sel;
            beat_cnt <= '0;
            state    <= BURST;
            busy     <= 1'b1;
          end
        end
        BURST: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          if (burst_done) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= exit_ptr;
          end
        end
      endcase
    end
  end

  // Outputs are gated by nrst so an abandoned burst cannot write during the reset cycle.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    if (nrst && (state == BURST)) begin
      req_ready[grant_id] = fifo_ready;
      fifo_wr_en          = g_valid && fifo_ready;
      fifo_data           = req_data[int'(grant_id)*WIDTH +: WIDTH];
    end
  end

endmodule
